// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map and FSM encoding.
package irq_ctrl_pkg;

    localparam logic [2:0] IRQ_PENDING = 3'd0;
    localparam logic [2:0] IRQ_MASK    = 3'd1;
    localparam logic [2:0] IRQ_CAUSE   = 3'd2;
    localparam logic [2:0] IRQ_EOI     = 3'd3;
    localparam logic [2:0] IRQ_STATUS  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder; bit 0 is the highest priority source.
module irq_prio_enc #(
    parameter int N_SRC = 8
) (
    input  logic [N_SRC-1:0] req,
    output logic             valid,
    output logic [3:0]       idx
);

    always_comb begin
        valid = |req;
        idx   = 4'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) idx = 4'(i);
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Edge-triggered interrupt controller: pending/mask registers, single in-flight
// request to the core with ack/EOI handshake.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src,
    output logic             irq_out,
    input  logic             irq_en,
    input  logic             irq_ack,
    input  logic             reg_ie,
    input  logic [2:0]       reg_sel,
    input  logic [15:0]      reg_in,
    output logic [15:0]      reg_out
);

    // state   | meaning
    // IDLE    | no request outstanding, scanning pending & mask
    // REQ     | irq_out high, waiting for core ack; idx frozen
    // SERVICE | core handling idx, waiting for EOI write

    irq_state_t       state, state_nxt;
    logic [3:0]       idx, idx_nxt;
    logic [N_SRC-1:0] src_q, src_edge;
    logic [N_SRC-1:0] pending, pending_nxt, mask, mask_nxt;
    logic [N_SRC-1:0] w1c, idx_hot;
    logic             wr_pending, wr_mask, wr_eoi, ack_take;
    logic             enc_valid;
    logic [3:0]       enc_idx;
    logic             unused_reg_in;

    assign unused_reg_in = &{1'b0, reg_in};

    assign src_edge   = irq_src & ~src_q;
    assign wr_pending = reg_ie && (reg_sel == IRQ_PENDING);
    assign wr_mask    = reg_ie && (reg_sel == IRQ_MASK);
    assign wr_eoi     = reg_ie && (reg_sel == IRQ_EOI);
    assign ack_take   = irq_ack && irq_en && (state == ST_REQ);
    assign w1c        = wr_pending ? reg_in[N_SRC-1:0] : '0;

    always_comb begin
        idx_hot = '0;
        for (int i = 0; i < N_SRC; i++) begin
            idx_hot[i] = (idx == 4'(i));
        end
    end

    // New edges win over both W1C and the ack clear of the in-service bit.
    assign pending_nxt = (pending & ~w1c & ~(ack_take ? idx_hot : '0)) | src_edge;
    assign mask_nxt    = wr_mask ? reg_in[N_SRC-1:0] : mask;

    irq_prio_enc #(.N_SRC(N_SRC)) u_prio_enc (
        .req   (pending & mask),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            ST_IDLE: begin
                if (enc_valid) begin
                    idx_nxt   = enc_idx;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                // Withdraw as soon as the selected line loses pending or mask,
                // judged on the values that land at this edge.
                if (ack_take) begin
                    state_nxt = ST_SERVICE;
                end else if (!(|(pending_nxt & mask_nxt & idx_hot))) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (wr_eoi) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q   <= irq_src;
            pending <= '0;
            mask    <= '0;
            idx     <= 4'd0;
            state   <= ST_IDLE;
            irq_out <= 1'b0;
        end else begin
            src_q   <= irq_src;
            pending <= pending_nxt;
            mask    <= mask_nxt;
            idx     <= idx_nxt;
            state   <= state_nxt;
            irq_out <= (state_nxt == ST_REQ);
        end
    end

    always_comb begin
        reg_out = 16'h0000;
        case (reg_sel)
            IRQ_PENDING: reg_out = 16'(pending);
            IRQ_MASK:    reg_out = 16'(mask);
            IRQ_CAUSE:   reg_out = {(state == ST_REQ) || (state == ST_SERVICE), 11'b0, idx};
            IRQ_STATUS:  reg_out = {14'b0, state};
            default:     reg_out = 16'h0000;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model.
module tb_irq_ctrl;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] irq_src = '0;
    logic         irq_out;
    logic         irq_en = 1'b1;
    logic         irq_ack = 1'b0;
    logic         reg_ie = 1'b0;
    logic [2:0]   reg_sel = 3'd0;
    logic [15:0]  reg_in = 16'h0;
    logic [15:0]  reg_out;

    always #5 clk = ~clk;

    irq_ctrl #(.N_SRC(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .irq_src (irq_src),
        .irq_out (irq_out),
        .irq_en  (irq_en),
        .irq_ack (irq_ack),
        .reg_ie  (reg_ie),
        .reg_sel (reg_sel),
        .reg_in  (reg_in),
        .reg_out (reg_out)
    );

    typedef struct {
        string       nm;
        logic        irq;
        logic [15:0] rd;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_pass = 0;

    // Behavioural model: 0 = idle, 1 = requesting, 2 = in service.
    bit [N-1:0] m_pend, m_mask, m_srcq;
    int         m_state = 0;
    int         m_idx = 0;

    function automatic logic [15:0] m_read(input logic [2:0] sel);
        logic [15:0] r;
        r = 16'h0;
        case (sel)
            3'd0: r = 16'(m_pend);
            3'd1: r = 16'(m_mask);
            3'd2: begin
                r[15]  = (m_state != 0);
                r[3:0] = 4'(m_idx);
            end
            3'd4: r[1:0] = 2'(m_state);
            default: r = 16'h0;
        endcase
        return r;
    endfunction

    task automatic m_update(input logic r, input logic [N-1:0] src, input logic en,
                            input logic ie, input logic [2:0] sel, input logic [15:0] din,
                            input logic ack);
        bit [N-1:0] e, w1c, pn, mn;
        bit         take;
        e      = src & ~m_srcq;
        m_srcq = src;
        if (r) begin
            m_pend  = '0;
            m_mask  = '0;
            m_idx   = 0;
            m_state = 0;
            return;
        end
        w1c  = (ie && sel == 3'd0) ? din[N-1:0] : '0;
        mn   = (ie && sel == 3'd1) ? din[N-1:0] : m_mask;
        take = (m_state == 1) && ack && en;
        pn   = m_pend & ~w1c;
        if (take) pn[m_idx] = 1'b0;
        pn = pn | e;
        case (m_state)
            0: if ((m_pend & m_mask) != 0) begin
                for (int i = 0; i < N; i++) begin
                    if (m_pend[i] && m_mask[i]) begin
                        m_idx = i;
                        break;
                    end
                end
                m_state = 1;
            end
            1: if (take) m_state = 2;
               else if (!pn[m_idx] || !mn[m_idx]) m_state = 0;
            2: if (ie && sel == 3'd3) m_state = 0;
            default: m_state = 0;
        endcase
        m_pend = pn;
        m_mask = mn;
    endtask

    // Drive one cycle; expected outputs for this cycle come from the model
    // (or from a fixed value for directed scenarios).
    task automatic cyc(input logic r, input logic [N-1:0] src, input logic ie,
                       input logic [2:0] sel, input logic [15:0] din, input logic ack,
                       input string nm, input bit cst = 1'b0, input logic ci = 1'b0,
                       input logic [15:0] cr = 16'h0);
        exp_t e;
        rst     = r;
        irq_src = src;
        reg_ie  = ie;
        reg_sel = sel;
        reg_in  = din;
        irq_ack = ack;
        e.nm = nm;
        if (cst) begin
            e.irq = ci;
            e.rd  = cr;
        end else begin
            e.irq = (m_state == 1);
            e.rd  = m_read(sel);
        end
        sb.push_back(e);
        @(posedge clk);
        m_update(r, src, irq_en, ie, sel, din, ack);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_chk++;
            if (irq_out === mon_e.irq && reg_out === mon_e.rd)
                n_pass++;
            else
                $display("FAIL %s: irq_out=%0b reg_out=%h, expected irq_out=%0b reg_out=%h",
                         mon_e.nm, irq_out, reg_out, mon_e.irq, mon_e.rd);
        end
    end

    initial begin
        logic [N-1:0] s;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        m_update(1'b1, '0, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
        #1;

        // single source, mask bit 0
        cyc(0, 8'h00, 0, 3'd4, 16'h0000, 0, "rst_status", 1, 0, 16'h0000);
        cyc(0, 8'h00, 0, 3'd0, 16'h0000, 0, "rst_pending", 1, 0, 16'h0000);
        cyc(0, 8'h00, 1, 3'd1, 16'h0001, 0, "rst_mask", 1, 0, 16'h0000);
        cyc(0, 8'h01, 0, 3'd0, 16'h0000, 0, "pre_edge");
        cyc(0, 8'h01, 0, 3'd0, 16'h0000, 0, "lat_pending", 1, 0, 16'h0001);
        cyc(0, 8'h01, 0, 3'd2, 16'h0000, 0, "lat_cause", 1, 1, 16'h8000);
        cyc(0, 8'h01, 0, 3'd2, 16'h0000, 1, "ack_cause", 1, 1, 16'h8000);
        cyc(0, 8'h01, 0, 3'd4, 16'h0000, 0, "svc_status", 1, 0, 16'h0002);
        cyc(0, 8'h01, 1, 3'd3, 16'h0000, 0, "eoi_write");
        cyc(0, 8'h00, 0, 3'd4, 16'h0000, 0, "eoi_idle", 1, 0, 16'h0000);

        // simultaneous sources 3 and 5
        cyc(0, 8'h00, 1, 3'd1, 16'h00FF, 0, "mask_ff");
        cyc(0, 8'h28, 0, 3'd0, 16'h0000, 0, "pre_35");
        cyc(0, 8'h28, 0, 3'd0, 16'h0000, 0, "pend_35", 1, 0, 16'h0028);
        cyc(0, 8'h28, 0, 3'd2, 16'h0000, 0, "cause_3", 1, 1, 16'h8003);
        cyc(0, 8'h28, 0, 3'd2, 16'h0000, 1, "ack_3");
        cyc(0, 8'h28, 0, 3'd0, 16'h0000, 0, "pend_after_ack", 1, 0, 16'h0020);
        cyc(0, 8'h28, 1, 3'd3, 16'h0000, 0, "eoi_35");
        cyc(0, 8'h28, 0, 3'd2, 16'h0000, 0, "idle_cause", 1, 0, 16'h0003);
        cyc(0, 8'h28, 0, 3'd2, 16'h0000, 0, "cause_5", 1, 1, 16'h8005);
        cyc(0, 8'h28, 0, 3'd0, 16'h0000, 1, "ack_5");
        cyc(0, 8'h00, 1, 3'd3, 16'h0000, 0, "eoi_5");

        // mask withdrawal while requesting
        cyc(0, 8'h04, 0, 3'd0, 16'h0000, 0, "pre_36");
        cyc(0, 8'h04, 0, 3'd0, 16'h0000, 0, "pend_36", 1, 0, 16'h0004);
        cyc(0, 8'h04, 0, 3'd2, 16'h0000, 0, "cause_2", 1, 1, 16'h8002);
        cyc(0, 8'h04, 1, 3'd1, 16'h0000, 0, "mask_off", 1, 1, 16'h00FF);
        cyc(0, 8'h04, 0, 3'd4, 16'h0000, 0, "wd_status", 1, 0, 16'h0000);
        cyc(0, 8'h04, 0, 3'd0, 16'h0000, 0, "wd_pending", 1, 0, 16'h0004);
        cyc(0, 8'h00, 1, 3'd0, 16'h0004, 0, "clr_36");

        // edge and W1C on the same bit
        cyc(0, 8'h02, 1, 3'd0, 16'h0002, 0, "w1c_edge");
        cyc(0, 8'h02, 0, 3'd0, 16'h0000, 0, "set_wins", 1, 0, 16'h0002);
        cyc(0, 8'h02, 1, 3'd0, 16'h00FF, 0, "clr_37");
        cyc(0, 8'h00, 0, 3'd0, 16'h0000, 0, "clr_37_chk", 1, 0, 16'h0000);

        // ack in idle, EOI while requesting
        cyc(0, 8'h00, 0, 3'd4, 16'h0000, 1, "ack_idle");
        cyc(0, 8'h00, 0, 3'd4, 16'h0000, 0, "ack_idle_st", 1, 0, 16'h0000);
        cyc(0, 8'h00, 0, 3'd0, 16'h0000, 0, "ack_idle_pend", 1, 0, 16'h0000);
        cyc(0, 8'h00, 1, 3'd1, 16'h0001, 0, "mask_01");
        cyc(0, 8'h01, 0, 3'd4, 16'h0000, 0, "pre_38");
        cyc(0, 8'h01, 0, 3'd4, 16'h0000, 0, "idle_38", 1, 0, 16'h0000);
        cyc(0, 8'h01, 1, 3'd3, 16'h0000, 0, "eoi_in_req", 1, 1, 16'h0000);
        cyc(0, 8'h01, 0, 3'd4, 16'h0000, 0, "eoi_req_st", 1, 1, 16'h0001);
        cyc(0, 8'h01, 0, 3'd0, 16'h0000, 0, "eoi_req_pend", 1, 1, 16'h0001);

        // reset while in service with sources held high
        cyc(0, 8'h01, 0, 3'd4, 16'h0000, 1, "ack_39");
        cyc(0, 8'h01, 0, 3'd4, 16'h0000, 0, "svc_39", 1, 0, 16'h0002);
        cyc(1, 8'hFF, 0, 3'd4, 16'h0000, 0, "rst_in_svc");
        cyc(0, 8'hFF, 0, 3'd0, 16'h0000, 0, "rst_pend", 1, 0, 16'h0000);
        cyc(0, 8'hFF, 1, 3'd1, 16'h00FF, 0, "rst_st0", 1, 0, 16'h0000);
        cyc(0, 8'hFF, 0, 3'd4, 16'h0000, 0, "rst_st1", 1, 0, 16'h0000);
        cyc(0, 8'hFF, 0, 3'd4, 16'h0000, 0, "rst_st2", 1, 0, 16'h0000);

        // randomized traffic
        s = 8'hFF;
        for (int i = 0; i < 800; i++) begin
            s      = s ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            irq_en = ($urandom_range(0, 4) != 0);
            cyc(($urandom_range(0, 149) == 0), s, ($urandom_range(0, 2) == 0),
                3'($urandom_range(0, 7)), 16'($urandom), ($urandom_range(0, 2) == 0), "rand");
        end

        irq_ack = 1'b0;
        reg_ie  = 1'b0;
        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter N_SRC, default 8, giving the number of interrupt source lines (1..15).
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 irq_src  in  N_SRC  peripheral interrupt lines, synchronous to clk, rising-edge triggered.
REQ-006 irq_out  out  1  interrupt request to core (drives core irq_in).
REQ-007 irq_en  in  1  core interrupt-enable (core SR1 bit 2); request is only taken when high.
REQ-008 irq_ack  in  1  one-cycle pulse from core: request accepted (core saw irq_in & irq_en).
REQ-009 reg_ie  in  1  register write strobe.
REQ-010 reg_sel  in  3  register select.
REQ-011 reg_in  in  16  register write data.
REQ-012 reg_out  out  16  register read data, combinational from reg_sel.

Function
REQ-013 Edge detect: src_q <= irq_src each cycle; edge[i] = irq_src[i] & ~src_q[i].
REQ-014 pending[i] SHALL be set on the clock where edge[i]=1, and SHALL stay 1 on further edges (no counting).
REQ-015 Registers: sel 0 PENDING (R; write = W1C on low N_SRC bits), sel 1 MASK (RW, 1 = enabled), sel 2 CAUSE (R), sel 3 EOI (W, data ignored), sel 4 STATUS (R), other sel: read 0, write ignored.
REQ-016 CAUSE read = {valid, 11'b0, idx[3:0]}; valid=1 in REQ or SERVICE. STATUS read = {14'b0, state[1:0]}.
REQ-017 FSM states IDLE=0, REQ=1, SERVICE=2; state 3 is unreachable and SHALL go to IDLE.
REQ-018 IDLE: if |(pending & mask), latch idx = lowest set index (index 0 highest priority) and go REQ next cycle.
REQ-019 REQ: irq_out=1 (registered, high exactly while state==REQ); idx frozen.
REQ-020 REQ + irq_ack: clear pending[idx], go SERVICE.
REQ-021 REQ without ack: if pending[idx] or mask[idx] becomes 0, return to IDLE (request withdrawn); higher-priority arrival does NOT change idx.
REQ-022 irq_ack in IDLE or SERVICE SHALL be ignored.
REQ-023 SERVICE: irq_out=0; new edges only set pending; EOI write returns to IDLE next cycle.
REQ-024 EOI in IDLE or REQ SHALL be ignored.
REQ-025 Same-cycle edge[i] and W1C of bit i: set wins (pending[i]=1).
REQ-026 Same-cycle irq_ack and W1C of pending[idx]: ack wins, go SERVICE.
REQ-027 Latency: src rise sampled at edge k -> pending=1 after k -> REQ and irq_out=1 after k+1, provided mask set and FSM IDLE.
REQ-028 Mask only gates request selection; masked lines still latch pending.

Reset
REQ-029 On rst: pending=0, mask=0, src_q=current irq_src (no spurious edge), idx=0, state=IDLE, irq_out=0.
REQ-030 rst mid-REQ or mid-SERVICE SHALL drop irq_out the next cycle and discard the in-service source.

Structure
REQ-031 Shared package holds register select constants (IRQ_PENDING..IRQ_STATUS) and FSM state encoding.
REQ-032 One sub-module irq_prio_enc: combinational N_SRC-bit lowest-index priority encoder with valid output.
REQ-033 Core interface is the initiator end of the core's irq_in/irq_en handshake; no other core signals used.

Verification
REQ-034 mask=0x01, irq_src[0] 0->1 at edge k -> irq_out=1 after k+1, CAUSE=0x8000.
REQ-035 mask=0xFF, src 3 and 5 rise same cycle -> CAUSE idx=3; ack -> PENDING=0x20; EOI -> next REQ with idx=5.
REQ-036 In REQ idx=2, write MASK=0x00 -> irq_out=0 next cycle, STATUS=0, PENDING bit 2 still 1.
REQ-037 Edge on src 1 same cycle as W1C 0x0002 -> PENDING bit 1 reads 1.
REQ-038 irq_ack pulse in IDLE and EOI in REQ -> no state change, no pending change.
REQ-039 rst asserted in SERVICE with irq_src held high -> irq_out=0, PENDING=0, no new REQ after reset.
